dma_line_engine: RTL and testbench
==================================

Name: dma_line_engine

Overview:
- Multi-line, bidirectional DMA engine between the host cache-line FIFOs and the word-wide memory controller DMA port.
- Host-to-memory (H2M): pops CL_SIZE_WIDTH-bit lines from the read FIFO, unpacks each line into WORD_SIZE-bit memory writes.
- Memory-to-host (M2H): issues word reads, packs the returned words into lines, pushes each line to the write FIFO.
- One command covers cmd_lines consecutive lines starting at a word address; generalises the single-line unpack/pack FSM.

Parameters:
CL_SIZE_WIDTH, 512, cache-line width in bits; must be an integer multiple of WORD_SIZE
WORD_SIZE, 32, memory word width in bits
ADDR_WIDTH, 28, memory word-address width
LEN_WIDTH, 16, width of the line-count field
(derived) WPL = CL_SIZE_WIDTH/WORD_SIZE, words per line; lane counter is clog2(WPL) bits

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle, command accepted when cmd_valid&cmd_ready
cmd_dir  in  1  0 = H2M, 1 = M2H
cmd_addr  in  ADDR_WIDTH  starting word address
cmd_lines  in  LEN_WIDTH  number of lines to move
empty  in  1  read FIFO empty (first-word-fall-through)
rd_en  out  1  pop read FIFO
dma_rd_data  in  CL_SIZE_WIDTH  read-FIFO head line
full  in  1  write FIFO full
wr_en  out  1  push write FIFO
dma_wr_data  out  CL_SIZE_WIDTH  line pushed to host
DMAEn  out  1  memory access strobe
DMAWrEn  out  1  1 = write, 0 = read (only meaningful with DMAEn)
DMAAddr  out  ADDR_WIDTH  memory word address
DMAData  out  WORD_SIZE  write data to memory
DMAOut  in  WORD_SIZE  read data from memory
DMAValid  in  1  read data valid
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (rst high at an edge): state IDLE. rd_en, wr_en, DMAEn, DMAWrEn, done and busy are 0. DMAAddr, DMAData and dma_wr_data are 0. Lane and line counters clear. cmd_ready is 0 while rst is high and 1 from the first cycle after.
- Reset mid-operation: the in-flight line is discarded. No further pops, pushes or memory strokes occur. done does not pulse.
- Lane order: lane k = bits [k*WORD_SIZE +: WORD_SIZE]. Lane 0 is moved first, at the lowest address. Line n, lane k maps to address cmd_addr + n*WPL + k, modulo 2^ADDR_WIDTH (wraps silently).
- IDLE: cmd_ready=1. On accept, latch dir, addr and lines, and set busy. If cmd_lines==0, go to DONE; else go to H2M_FETCH or M2H_REQ.
- H2M_FETCH: wait while empty. When !empty, assert rd_en for exactly one cycle, latch dma_rd_data into the line buffer, then go to H2M_WRITE.
- H2M_WRITE: one word per cycle for WPL cycles, no stalls. DMAEn=1, DMAWrEn=1, DMAAddr=addr, DMAData=lane k; each cycle k++ and addr++.
  - After lane WPL-1, decrement lines. If lines remain, go to H2M_FETCH; else go to DONE.
  - Minimum of one idle cycle per line in FETCH.
- M2H_REQ: one cycle with DMAEn=1, DMAWrEn=0, DMAAddr=addr, then go to M2H_WAIT.
- M2H_WAIT: hold DMAEn=0 until DMAValid. On DMAValid, store DMAOut into lane k and addr++.
  - If k==WPL-1, go to M2H_PUSH; else k++ and go to M2H_REQ.
  - DMAValid in any other state is ignored.
- M2H_PUSH: dma_wr_data = packed buffer, held stable. Wait while full. When !full, assert wr_en for exactly one cycle and decrement lines. If lines remain, go to M2H_REQ with k=0; else go to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE. A new command can be accepted the following cycle.
- cmd_valid outside IDLE is ignored; cmd fields are sampled only at accept.
- The memory controller accepts writes in the cycle presented; it never back-pressures writes.

Test Plan:
- H2M, 1 line, cmd_addr=0x100, FIFO line with lane k = 15-k -> exactly one rd_en pulse; 16 consecutive writes to 0x100..0x10F with data 15,14,...,0; done pulses 1 cycle after the 0x10F write; busy=0 afterward.
- H2M, 2 lines, empty held high 5 cycles between lines -> no DMAEn during the stall; second line written to 0x110..0x11F; two rd_en pulses total.
- M2H, 1 line, cmd_addr=0x40, memory returning DMAOut = address[3:0] with 2-cycle latency; full held high 3 cycles at push -> dma_wr_data lane k = k; wr_en single pulse only after full drops; 16 read strobes, each separated by the wait.
- cmd_lines=0 -> done pulses 2 cycles after accept; no DMAEn, rd_en or wr_en ever asserted.
- H2M, cmd_addr=0xFFFFFF8, 1 line -> addresses 0xFFFFFF8..0xFFFFFFF then 0x0000000..0x0000007.
- rst pulsed during H2M lane 5 -> all strobes 0 the next cycle; no done; cmd_ready=1 after; a fresh 1-line M2H command completes correctly.

Source files
------------

// File: rtl/dma_line_engine.sv
// Multi-line bidirectional DMA engine: unpacks host cache lines into word writes
// (H2M) or packs word reads into host cache lines (M2H), cmd_lines lines per command.
module dma_line_engine #(
  parameter int CL_SIZE_WIDTH = 512,
  parameter int WORD_SIZE     = 32,
  parameter int ADDR_WIDTH    = 28,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_dir,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_lines,
  input  logic                     empty,
  output logic                     rd_en,
  input  logic [CL_SIZE_WIDTH-1:0] dma_rd_data,
  input  logic                     full,
  output logic                     wr_en,
  output logic [CL_SIZE_WIDTH-1:0] dma_wr_data,
  output logic                     DMAEn,
  output logic                     DMAWrEn,
  output logic [ADDR_WIDTH-1:0]    DMAAddr,
  output logic [WORD_SIZE-1:0]     DMAData,
  input  logic [WORD_SIZE-1:0]     DMAOut,
  input  logic                     DMAValid,
  output logic                     busy,
  output logic                     done
);

  localparam int WPL = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int LW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(WPL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_H2M_FETCH,
    S_H2M_WRITE,
    S_M2H_REQ,
    S_M2H_WAIT,
    S_M2H_PUSH,
    S_DONE
  } state_t;

  state_t                   state;
  logic [CL_SIZE_WIDTH-1:0] line_buf;
  logic [CL_SIZE_WIDTH-1:0] line_ins;
  logic [WORD_SIZE-1:0]     lane_word;
  logic [LW-1:0]            lane;
  logic [LEN_WIDTH-1:0]     lines_left;
  logic [ADDR_WIDTH-1:0]    addr_r;

  assign lane_word = line_buf[lane*WORD_SIZE +: WORD_SIZE];

  // Line buffer with the current lane replaced by the returning memory word
  always_comb begin
    line_ins = line_buf;
    line_ins[lane*WORD_SIZE +: WORD_SIZE] = DMAOut;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      DMAEn       <= 1'b0;
      DMAWrEn     <= 1'b0;
      DMAAddr     <= '0;
      DMAData     <= '0;
      dma_wr_data <= '0;
      line_buf    <= '0;
      lane        <= '0;
      lines_left  <= '0;
      addr_r      <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      DMAEn   <= 1'b0;
      DMAWrEn <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            addr_r     <= cmd_addr;
            lines_left <= cmd_lines;
            lane       <= '0;
            if (cmd_lines == '0)
              state <= S_DONE;
            else if (cmd_dir)
              state <= S_M2H_REQ;
            else
              state <= S_H2M_FETCH;
          end
        end
        S_H2M_FETCH: begin
          if (!empty) begin
            rd_en    <= 1'b1;
            line_buf <= dma_rd_data;
            lane     <= '0;
            state    <= S_H2M_WRITE;
          end
        end
        S_H2M_WRITE: begin
          DMAEn   <= 1'b1;
          DMAWrEn <= 1'b1;
          DMAAddr <= addr_r;
          DMAData <= lane_word;
          addr_r  <= addr_r + ADDR_WIDTH'(1);
          if (lane == LAST_LANE) begin
            lane       <= '0;
            lines_left <= lines_left - LEN_WIDTH'(1);
            state      <= (lines_left == LEN_WIDTH'(1)) ? S_DONE : S_H2M_FETCH;
          end else begin
            lane <= lane + LW'(1);
          end
        end
        S_M2H_REQ: begin
          DMAEn   <= 1'b1;
          DMAAddr <= addr_r;
          state   <= S_M2H_WAIT;
        end
        S_M2H_WAIT: begin
          if (DMAValid) begin
            line_buf <= line_ins;
            addr_r   <= addr_r + ADDR_WIDTH'(1);
            if (lane == LAST_LANE) begin
              dma_wr_data <= line_ins;
              state       <= S_M2H_PUSH;
            end else begin
              lane  <= lane + LW'(1);
              state <= S_M2H_REQ;
            end
          end
        end
        S_M2H_PUSH: begin
          if (!full) begin
            wr_en      <= 1'b1;
            lane       <= '0;
            lines_left <= lines_left - LEN_WIDTH'(1);
            state      <= (lines_left == LEN_WIDTH'(1)) ? S_DONE : S_M2H_REQ;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_line_engine.sv
// Directed bench for dma_line_engine: command table plus stall, back-pressure and
// mid-operation reset sequences against a FIFO/memory responder.
module tb_dma_line_engine;
  localparam int CLW = 512;
  localparam int WS  = 32;
  localparam int AW  = 28;
  localparam int LW  = 16;
  localparam int WPL = CLW / WS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_dir = 1'b0;
  logic [AW-1:0]  cmd_addr = '0;
  logic [LW-1:0]  cmd_lines = '0;
  logic           empty = 1'b1;
  logic           rd_en;
  logic [CLW-1:0] dma_rd_data;
  logic           full = 1'b0;
  logic           wr_en;
  logic [CLW-1:0] dma_wr_data;
  logic           DMAEn, DMAWrEn;
  logic [AW-1:0]  DMAAddr;
  logic [WS-1:0]  DMAData;
  logic [WS-1:0]  DMAOut;
  logic           DMAValid;
  logic           busy, done;

  logic           mem_v = 1'b0;
  logic [WS-1:0]  mem_d = '0;
  logic           stray_v = 1'b0;

  int cyc = 0;
  int pops = 0;
  int pop_base = 0;
  int done_cnt = 0;
  int due = -1;
  int acc_cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [AW-1:0] maddr = '0;

  logic [AW-1:0]  wa_q[$];
  logic [WS-1:0]  wd_q[$];
  int             wc_q[$];
  logic [AW-1:0]  ra_q[$];
  int             rc_q[$];
  logic [CLW-1:0] pd_q[$];
  int             pc_q[$];

  typedef struct {
    logic          dir;
    logic [AW-1:0] addr;
    logic [LW-1:0] lines;
    int            e_wr;
    int            e_rd;
    int            e_pop;
    int            e_push;
    logic [AW-1:0] e_first;
    logic [AW-1:0] e_last;
    int            e_lat;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [CLW-1:0] make_line(input int n);
    logic [CLW-1:0] l;
    for (int k = 0; k < WPL; k++) l[k*WS +: WS] = WS'((n << 8) | (15 - k));
    return l;
  endfunction

  assign dma_rd_data = make_line(pops - pop_base);
  assign DMAValid    = mem_v | stray_v;
  assign DMAOut      = stray_v ? 32'hDEAD_BEEF : mem_d;

  dma_line_engine #(.CL_SIZE_WIDTH(CLW), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_lines(cmd_lines),
    .empty(empty), .rd_en(rd_en), .dma_rd_data(dma_rd_data),
    .full(full), .wr_en(wr_en), .dma_wr_data(dma_wr_data),
    .DMAEn(DMAEn), .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr), .DMAData(DMAData),
    .DMAOut(DMAOut), .DMAValid(DMAValid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns address[3:0] two cycles after each read strobe
  always @(negedge clk) begin
    if (cyc == due) begin
      mem_v = 1'b1;
      mem_d = {{(WS-4){1'b0}}, maddr[3:0]};
    end else begin
      mem_v = 1'b0;
    end
    if (DMAEn && DMAWrEn) begin
      wa_q.push_back(DMAAddr); wd_q.push_back(DMAData); wc_q.push_back(cyc);
    end
    if (DMAEn && !DMAWrEn) begin
      ra_q.push_back(DMAAddr); rc_q.push_back(cyc);
      due   = cyc + 2;
      maddr = DMAAddr;
    end
    if (rd_en) pops++;
    if (wr_en) begin
      pd_q.push_back(dma_wr_data); pc_q.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic d, input logic [AW-1:0] a, input logic [LW-1:0] n);
    int t;
    @(negedge clk);
    cmd_dir = d; cmd_addr = a; cmd_lines = n; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("issue_accept", 64'(t < 50), 64'd1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_dir = ~d; cmd_addr = 28'hABCDEF0; cmd_lines = 16'd7;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string nm, input int budget, output int dcyc);
    int t;
    t = 0;
    while (done !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    check({nm, "_done_seen"}, 64'(t < budget), 64'd1);
    dcyc = cyc;
    @(negedge clk);
    check({nm, "_done_one_cycle"}, 64'(done), 64'd0);
    check({nm, "_busy_low"}, 64'(busy), 64'd0);
    check({nm, "_ready_high"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int w0, r0, p0, pop0, d0, dc, nw, nr, np;
    logic [AW-1:0] a;
    w0 = wa_q.size(); r0 = ra_q.size(); p0 = pd_q.size(); pop0 = pops; d0 = done_cnt;
    pop_base = pops; empty = 1'b0; full = 1'b0;
    issue(v.dir, v.addr, v.lines);
    wait_done(tag, 600, dc);
    repeat (2) @(negedge clk);
    nw = wa_q.size() - w0; nr = ra_q.size() - r0; np = pd_q.size() - p0;
    check({tag, "_writes"}, 64'(nw), 64'(v.e_wr));
    check({tag, "_reads"}, 64'(nr), 64'(v.e_rd));
    check({tag, "_pops"}, 64'(pops - pop0), 64'(v.e_pop));
    check({tag, "_pushes"}, 64'(np), 64'(v.e_push));
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    if (v.e_lat > 0) check({tag, "_done_latency"}, 64'(dc - acc_cyc), 64'(v.e_lat));
    if (nw == v.e_wr && v.e_wr > 0) begin
      check({tag, "_first_addr"}, 64'(wa_q[w0]), 64'(v.e_first));
      check({tag, "_last_addr"}, 64'(wa_q[w0+nw-1]), 64'(v.e_last));
      check({tag, "_done_after_write"}, 64'(dc), 64'(wc_q[w0+nw-1] + 1));
      for (int i = 0; i < nw; i++) begin
        check($sformatf("%s_waddr%0d", tag, i), 64'(wa_q[w0+i]), 64'(AW'(v.addr + AW'(i))));
        check($sformatf("%s_wdata%0d", tag, i), 64'(wd_q[w0+i]),
              64'(WS'(((i / WPL) << 8) | (15 - (i % WPL)))));
        if (i % WPL != 0)
          check($sformatf("%s_wcyc%0d", tag, i), 64'(wc_q[w0+i]), 64'(wc_q[w0+i-1] + 1));
      end
    end
    if (nr == v.e_rd && v.e_rd > 0) begin
      check({tag, "_first_raddr"}, 64'(ra_q[r0]), 64'(v.e_first));
      check({tag, "_last_raddr"}, 64'(ra_q[r0+nr-1]), 64'(v.e_last));
      for (int i = 0; i < nr; i++)
        check($sformatf("%s_raddr%0d", tag, i), 64'(ra_q[r0+i]), 64'(AW'(v.addr + AW'(i))));
    end
    if (np == v.e_push && v.e_push > 0) begin
      check({tag, "_done_after_push"}, 64'(dc), 64'(pc_q[p0+np-1] + 1));
      for (int n = 0; n < np; n++)
        for (int k = 0; k < WPL; k++) begin
          a = AW'(v.addr + AW'(n * WPL + k));
          check($sformatf("%s_line%0d_lane%0d", tag, n, k),
                64'(pd_q[p0+n][k*WS +: WS]), 64'({28'b0, a[3:0]}));
        end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, w0, r0, p0, pop0, d0, dc;
    vec_t v;
    vecs[0] = '{1'b0, 28'h0000100, 16'd1, 16, 0, 1, 0, 28'h0000100, 28'h000010F, -1};
    vecs[1] = '{1'b0, 28'hFFFFFF8, 16'd1, 16, 0, 1, 0, 28'hFFFFFF8, 28'h0000007, -1};
    vecs[2] = '{1'b1, 28'h0000040, 16'd1, 0, 16, 0, 1, 28'h0000040, 28'h000004F, -1};
    vecs[3] = '{1'b0, 28'h0000123, 16'd0, 0, 0, 0, 0, 28'h0, 28'h0, 2};
    vecs[4] = '{1'b1, 28'h0000123, 16'd0, 0, 0, 0, 0, 28'h0, 28'h0, 2};
    vecs[5] = '{1'b0, 28'h0000200, 16'd3, 48, 0, 3, 0, 28'h0000200, 28'h000022F, -1};
    vecs[6] = '{1'b1, 28'hFFFFFF0, 16'd2, 0, 32, 0, 2, 28'hFFFFFF0, 28'h000000F, -1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_strobes", 64'({rd_en, wr_en, DMAEn, DMAWrEn, done, busy}), 64'd0);
    check("rst_dmaaddr", 64'(DMAAddr), 64'd0);
    check("rst_dmadata", 64'(DMAData), 64'd0);
    check("rst_wr_data_nz", 64'(|dma_wr_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // H2M two lines with the read FIFO empty between lines
    w0 = wa_q.size(); pop0 = pops; pop_base = pops; empty = 1'b0;
    issue(1'b0, 28'h0000100, 16'd2);
    t = 0;
    while (rd_en !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("stall_first_pop", 64'(t < 50), 64'd1);
    empty = 1'b1;
    t = 0;
    while (!(DMAEn === 1'b1 && DMAAddr === 28'h000010F) && t < 50) begin @(negedge clk); t++; end
    check("stall_line0_end", 64'(t < 50), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_no_dmaen%0d", i), 64'(DMAEn), 64'd0);
      check($sformatf("stall_no_pop%0d", i), 64'(rd_en), 64'd0);
    end
    empty = 1'b0;
    wait_done("stall", 200, dc);
    repeat (2) @(negedge clk);
    check("stall_pops", 64'(pops - pop0), 64'd2);
    check("stall_writes", 64'(wa_q.size() - w0), 64'd32);
    if (wa_q.size() - w0 == 32)
      for (int i = 0; i < 32; i++) begin
        check($sformatf("stall_waddr%0d", i), 64'(wa_q[w0+i]), 64'(28'h100 + i));
        check($sformatf("stall_wdata%0d", i), 64'(wd_q[w0+i]),
              64'(((i / WPL) << 8) | (15 - (i % WPL))));
      end

    // M2H with the write FIFO full at push time and a stray DMAValid
    r0 = ra_q.size(); p0 = pd_q.size(); full = 1'b1;
    issue(1'b1, 28'h0000040, 16'd1);
    t = 0;
    while (!(DMAEn === 1'b1 && DMAWrEn === 1'b0 && DMAAddr === 28'h000004F) && t < 200) begin
      @(negedge clk); t++;
    end
    check("full_last_read_seen", 64'(t < 200), 64'd1);
    repeat (3) @(negedge clk);
    check("full_no_push0", 64'(wr_en), 64'd0);
    @(negedge clk);
    stray_v = 1'b1;
    check("full_no_push1", 64'(wr_en), 64'd0);
    @(negedge clk);
    stray_v = 1'b0;
    check("full_no_push2", 64'(wr_en), 64'd0);
    @(negedge clk);
    check("full_no_push3", 64'(wr_en), 64'd0);
    full = 1'b0;
    wait_done("full", 50, dc);
    repeat (2) @(negedge clk);
    check("full_pushes", 64'(pd_q.size() - p0), 64'd1);
    check("full_reads", 64'(ra_q.size() - r0), 64'd16);
    if (pd_q.size() - p0 == 1)
      for (int k = 0; k < WPL; k++)
        check($sformatf("full_lane%0d", k), 64'(pd_q[p0][k*WS +: WS]), 64'(k));
    if (ra_q.size() - r0 == 16)
      for (int i = 1; i < 16; i++)
        check($sformatf("full_read_gap%0d", i), 64'(rc_q[r0+i] - rc_q[r0+i-1]), 64'd4);

    // Reset during H2M lane 5, then a fresh M2H command
    w0 = wa_q.size(); pop0 = pops; d0 = done_cnt; pop_base = pops; empty = 1'b0;
    issue(1'b0, 28'h0000300, 16'd1);
    t = 0;
    while (!(DMAEn === 1'b1 && DMAAddr === 28'h0000305) && t < 50) begin @(negedge clk); t++; end
    check("mid_rst_lane5_seen", 64'(t < 50), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_strobes", 64'({rd_en, wr_en, DMAEn, DMAWrEn, done, busy}), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_dmaaddr", 64'(DMAAddr), 64'd0);
    rst = 1'b0;
    empty = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_after", 64'(cmd_ready), 64'd1);
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_rst_writes", 64'(wa_q.size() - w0), 64'd6);
    check("mid_rst_pops", 64'(pops - pop0), 64'd1);
    v = '{1'b1, 28'h0000040, 16'd1, 0, 16, 0, 1, 28'h0000040, 28'h000004F, -1};
    run_vec(v, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
